// File: rtl/contador_tempo_musica_pkg.sv
// rtl/contador_tempo_musica_pkg.sv - shared constants for the elapsed-time counter
package contador_tempo_musica_pkg;

    localparam int ADDRS_POR_SEGUNDO = 3000;
    localparam int SALTO_10          = 10;
    localparam int SALTO_30          = 30;
    localparam int SEG_POR_MIN       = 60;
    localparam int BCD_W             = 4;

endpackage

// File: rtl/bin_para_bcd_2dig.sv
// rtl/bin_para_bcd_2dig.sv - combinational 7-bit binary (0..99) to two BCD digits
module bin_para_bcd_2dig
    import contador_tempo_musica_pkg::*;
(
    input  logic [6:0]       valor,
    output logic [BCD_W-1:0] dezena,
    output logic [BCD_W-1:0] unidade
);

    // Threshold search instead of a divider; inputs above 99 are never produced.
    always_comb begin
        dezena  = '0;
        unidade = BCD_W'(valor);
        for (int i = 1; i <= 9; i++) begin
            if (valor >= 7'(10 * i)) begin
                dezena  = BCD_W'(i);
                unidade = BCD_W'(valor - 7'(10 * i));
            end
        end
    end

endmodule

// File: rtl/contador_tempo_musica.sv
// rtl/contador_tempo_musica.sv - mm:ss elapsed-time counter with saturating jumps and BCD outputs
module contador_tempo_musica #(
    parameter int ADDRS_POR_SEGUNDO = contador_tempo_musica_pkg::ADDRS_POR_SEGUNDO,
    parameter int MAX_MIN           = 99
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        count,
    input  logic                                        prox_musica,
    input  logic                                        salto_valido,
    input  logic signed [8:0]                           salto_valor,
    output logic [contador_tempo_musica_pkg::BCD_W-1:0] min_dezena,
    output logic [contador_tempo_musica_pkg::BCD_W-1:0] min_unidade,
    output logic [contador_tempo_musica_pkg::BCD_W-1:0] seg_dezena,
    output logic [contador_tempo_musica_pkg::BCD_W-1:0] seg_unidade,
    output logic                                        fim_contagem
);

    import contador_tempo_musica_pkg::*;

    localparam int PRE_W = $clog2(ADDRS_POR_SEGUNDO);
    localparam logic [PRE_W-1:0] PRE_ULTIMO = PRE_W'(ADDRS_POR_SEGUNDO - 1);

    logic [PRE_W-1:0] pre;
    logic [6:0]       min;
    logic [5:0]       seg;

    logic             tick;
    logic [PRE_W-1:0] pre_next;
    logic signed [9:0] delta;
    logic signed [9:0] total;
    logic signed [8:0] min_tmp;
    logic [5:0]       seg_tmp;
    logic [6:0]       min_next;
    logic [5:0]       seg_next;
    logic             fim_next;

    logic [BCD_W-1:0] md_next, mu_next, sd_next, su_next;

    always_comb begin
        tick     = count && (pre == PRE_ULTIMO);
        pre_next = pre;
        if (count) begin
            pre_next = tick ? '0 : pre + 1'b1;
        end
    end

    always_comb begin
        delta = (salto_valido ? {salto_valor[8], salto_valor} : 10'sd0)
              + (tick ? 10'sd1 : 10'sd0);
        total = $signed({4'b0000, seg}) + delta;

        // |delta| <= 60, so at most one carry or borrow into the minutes.
        if (total >= 10'(SEG_POR_MIN)) begin
            seg_tmp = 6'(total - 10'(SEG_POR_MIN));
            min_tmp = $signed({2'b00, min}) + 9'sd1;
        end else if (total < 10'sd0) begin
            seg_tmp = 6'(total + 10'(SEG_POR_MIN));
            min_tmp = $signed({2'b00, min}) - 9'sd1;
        end else begin
            seg_tmp = 6'(total);
            min_tmp = $signed({2'b00, min});
        end

        if (min_tmp < 9'sd0) begin
            min_next = '0;
            seg_next = '0;
        end else if (min_tmp > 9'(MAX_MIN)) begin
            min_next = 7'(MAX_MIN);
            seg_next = 6'(SEG_POR_MIN - 1);
        end else begin
            min_next = 7'(min_tmp);
            seg_next = seg_tmp;
        end

        fim_next = (min_next == 7'(MAX_MIN)) && (seg_next == 6'(SEG_POR_MIN - 1));
    end

    bin_para_bcd_2dig u_bcd_min (
        .valor   (min_next),
        .dezena  (md_next),
        .unidade (mu_next)
    );

    bin_para_bcd_2dig u_bcd_seg (
        .valor   ({1'b0, seg_next}),
        .dezena  (sd_next),
        .unidade (su_next)
    );

    always_ff @(posedge clk) begin
        if (reset || prox_musica) begin
            pre          <= '0;
            min          <= '0;
            seg          <= '0;
            min_dezena   <= '0;
            min_unidade  <= '0;
            seg_dezena   <= '0;
            seg_unidade  <= '0;
            fim_contagem <= 1'b0;
        end else begin
            pre          <= pre_next;
            min          <= min_next;
            seg          <= seg_next;
            min_dezena   <= md_next;
            min_unidade  <= mu_next;
            seg_dezena   <= sd_next;
            seg_unidade  <= su_next;
            fim_contagem <= fim_next;
        end
    end

endmodule

// File: tb/tb_contador_tempo_musica.sv
// tb/tb_contador_tempo_musica.sv - self-checking bench for contador_tempo_musica
module tb_contador_tempo_musica;

    localparam int RATE   = 3000;
    localparam int MAXMIN = 99;
    localparam int TETO   = MAXMIN * 60 + 59;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              count = 1'b0;
    logic              prox_musica = 1'b0;
    logic              salto_valido = 1'b0;
    logic signed [8:0] salto_valor = '0;
    logic [3:0]        min_dezena, min_unidade, seg_dezena, seg_unidade;
    logic              fim_contagem;

    int checks = 0;
    int failures = 0;

    contador_tempo_musica #(.ADDRS_POR_SEGUNDO(RATE), .MAX_MIN(MAXMIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .count        (count),
        .prox_musica  (prox_musica),
        .salto_valido (salto_valido),
        .salto_valor  (salto_valor),
        .min_dezena   (min_dezena),
        .min_unidade  (min_unidade),
        .seg_dezena   (seg_dezena),
        .seg_unidade  (seg_unidade),
        .fim_contagem (fim_contagem)
    );

    always #5 clk = ~clk;

    // Model: elapsed time as a plain count of seconds, clamped to [0, TETO].
    int m_tempo = 0;
    int m_strobes = 0;
    bit started = 0;

    always @(posedge clk) begin
        int d;
        started = 1;
        if (reset || prox_musica) begin
            m_tempo   = 0;
            m_strobes = 0;
        end else begin
            d = 0;
            if (count) begin
                m_strobes++;
                if (m_strobes == RATE) begin
                    m_strobes = 0;
                    d = 1;
                end
            end
            if (salto_valido) d += int'(salto_valor);
            m_tempo += d;
            if (m_tempo < 0) m_tempo = 0;
            if (m_tempo > TETO) m_tempo = TETO;
        end
    end

    function automatic logic [16:0] esperado(input int t);
        int mm, ss;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), t == TETO};
    endfunction

    always @(negedge clk) begin
        logic [16:0] exp_v, act_v;
        if (started) begin
            exp_v = esperado(m_tempo);
            act_v = {min_dezena, min_unidade, seg_dezena, seg_unidade, fim_contagem};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL per_cycle t=%0t got %h%h:%h%h fim=%b expected %h%h:%h%h fim=%b",
                         $time, act_v[16:13], act_v[12:9], act_v[8:5], act_v[4:1], act_v[0],
                         exp_v[16:13], exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    end

    task automatic step(input logic c, input logic p, input logic sv, input int v, input logic r);
        @(negedge clk);
        count        = c;
        prox_musica  = p;
        salto_valido = sv;
        salto_valor  = 9'(v);
        reset        = r;
        @(posedge clk);
        #1;
        count        = 1'b0;
        prox_musica  = 1'b0;
        salto_valido = 1'b0;
        salto_valor  = '0;
        reset        = 1'b0;
    endtask

    task automatic strobes(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic jump(input int v);
        step(1'b0, 1'b0, 1'b1, v, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    // Hand-computed literal expectation, checked against both the DUT and the model.
    task automatic check_lit(input string name, input int mm, input int ss, input logic fim);
        logic [16:0] lit, act_v;
        lit   = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), fim};
        act_v = {min_dezena, min_unidade, seg_dezena, seg_unidade, fim_contagem};
        checks++;
        if (act_v !== lit) begin
            failures++;
            $display("FAIL %s dut got %h%h:%h%h fim=%b expected %02d:%02d fim=%b",
                     name, act_v[16:13], act_v[12:9], act_v[8:5], act_v[4:1], act_v[0], mm, ss, fim);
        end
        checks++;
        if (m_tempo != mm * 60 + ss) begin
            failures++;
            $display("FAIL %s_model got %0d s expected %0d s", name, m_tempo, mm * 60 + ss);
        end
    endtask

    initial begin
        // 1: reset state, 6000 strobes, idle, exact tick boundary
        do_reset();
        check_lit("reset", 0, 0, 1'b0);
        strobes(6000);
        check_lit("s1_6000", 0, 2, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_lit("s1_idle", 0, 2, 1'b0);
        strobes(RATE - 1);
        check_lit("s1_pre2999", 0, 2, 1'b0);
        strobes(1);
        check_lit("s1_tick", 0, 3, 1'b0);

        // 2: jumps with carry, borrow and floor saturation
        do_reset();
        jump(30); jump(10); jump(5);
        check_lit("s2_045", 0, 45, 1'b0);
        jump(30);
        check_lit("s2_plus30", 1, 15, 1'b0);
        jump(-10);
        check_lit("s2_105", 1, 5, 1'b0);
        jump(-10);
        check_lit("s2_minus10_borrow", 0, 55, 1'b0);
        jump(-30); jump(-10); jump(-10);
        check_lit("s2_005", 0, 5, 1'b0);
        jump(-10);
        check_lit("s2_floor", 0, 0, 1'b0);
        jump(59); jump(59);
        check_lit("s2_plus59", 1, 58, 1'b0);
        jump(-59);
        check_lit("s2_minus59", 0, 59, 1'b0);

        // 3: tick and jump in the same cycle
        do_reset();
        jump(30); jump(29);
        strobes(RATE - 1);
        check_lit("s3_059", 0, 59, 1'b0);
        step(1'b1, 1'b0, 1'b1, 30, 1'b0);
        check_lit("s3_tick_jump", 1, 30, 1'b0);
        strobes(RATE - 1);
        check_lit("s3_pre_restart", 1, 30, 1'b0);
        strobes(1);
        check_lit("s3_next_tick", 1, 31, 1'b0);

        // 4: ceiling saturation
        do_reset();
        repeat (199) jump(30);
        jump(10); jump(10);
        check_lit("s4_9950", 99, 50, 1'b0);
        jump(30);
        check_lit("s4_ceiling", 99, 59, 1'b1);
        strobes(RATE);
        check_lit("s4_ticks_at_ceiling", 99, 59, 1'b1);
        jump(-10);
        check_lit("s4_minus10", 99, 49, 1'b0);

        // 5: next song clears time and prescaler
        do_reset();
        jump(10);
        strobes(1500);
        check_lit("s5_010", 0, 10, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        check_lit("s5_prox", 0, 0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b1, 30, 1'b0);
        check_lit("s5_prox_held", 0, 0, 1'b0);
        strobes(RATE - 1);
        check_lit("s5_no_early_tick", 0, 0, 1'b0);
        strobes(1);
        check_lit("s5_full_second", 0, 1, 1'b0);

        // 6: reset beats a simultaneous jump
        do_reset();
        repeat (4) jump(30);
        check_lit("s6_200", 2, 0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 30, 1'b1);
        check_lit("s6_reset_wins", 0, 0, 1'b0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_tempo_musica.md
# contador_tempo_musica

Elapsed-time counter for the music player. It sits downstream of the current-address state machine and consumes the same 3 kHz `count` strobe that advances the address, plus that machine's seek and next-song events. It keeps the track's elapsed time as mm:ss, applies ±10 s and ±30 s jumps with saturation, and drives four BCD digits to the 7-segment time display.

## Interface
Parameters:
- `ADDRS_POR_SEGUNDO`, default 3000: `count` strobes per second of audio. Must equal the address machine's rate.
- `MAX_MIN`, default 99: largest displayable minute value. The ceiling is `MAX_MIN`:59.

Ports:
- `clk`, input, 1: system clock. One clock domain; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `count`, input, 1: playback strobe, one pulse per address step. Low while paused.
- `prox_musica`, input, 1: next-song event. Clears time to 00:00.
- `salto_valido`, input, 1: one-cycle pulse; apply `salto_valor`.
- `salto_valor`, input, 9, signed: jump in seconds. Legal values are -30, -10, +10, +30. Any value in [-59, +59] must still be handled correctly.
- `min_dezena`, output, 4: minutes tens digit, BCD.
- `min_unidade`, output, 4: minutes units digit, BCD.
- `seg_dezena`, output, 4: seconds tens digit, BCD, range 0..5.
- `seg_unidade`, output, 4: seconds units digit, BCD.
- `fim_contagem`, output, 1: high while time equals `MAX_MIN`:59.

## Operation
- State registers:
  - prescaler `pre`, ceil(log2(`ADDRS_POR_SEGUNDO`)) bits, range 0..`ADDRS_POR_SEGUNDO`-1
  - `min`, 7 bits binary
  - `seg`, 6 bits binary
  - the BCD output registers
- Second tick: on `count`=1, `pre` increments. When `count`=1 and `pre`=`ADDRS_POR_SEGUNDO`-1, `pre` returns to 0 and a tick of +1 s is generated. No counting occurs while `count`=0.
- Priority, highest first: `reset`, then `prox_musica`, then (`salto_valido` combined with tick).
- `reset` or `prox_musica`: `pre`=0, time 00:00, all digits 0, `fim_contagem`=0.
- Net delta per cycle = (`salto_valido` ? `salto_valor` : 0) + (tick ? 1 : 0). A jump and a tick in the same cycle are both applied.
- A jump does not touch `pre`.
- Arithmetic on signed total = `seg` + delta, computed in at least 8 bits signed:
  - total ≥ 60: `seg` = total-60, `min`+1.
  - total < 0: `seg` = total+60, `min`-1.
  - At most one carry or borrow can occur, since |delta| ≤ 60.
- Saturation:
  - If the result would fall below 00:00, the time becomes 00:00.
  - If the result would exceed `MAX_MIN`:59, the time becomes `MAX_MIN`:59.
  - Time never wraps.
  - At the ceiling, ticks leave the time unchanged.
- BCD digits are computed from the next-state `min`/`seg` and registered, so digits always match the internal time.

## Timing
- Reset values: all digits 0, `fim_contagem`=0, `pre`=0.
- Latency: an event sampled at edge N is visible on all outputs after edge N. Outputs are registered with one cycle of latency and no combinational path from inputs to outputs.
- `salto_valido` is level-sampled each cycle. Held high for k cycles, the jump is applied k times. Upstream must pulse it for exactly one cycle.
- `prox_musica` held high keeps the counter at 00:00 and `pre` at 0.
- `reset` asserted during a jump or tick cycle: reset wins and the event is discarded.

## Structure
- Shared package:
  - `ADDRS_POR_SEGUNDO` (3000), shared with the address machine
  - jump constants `SALTO_10`=10 and `SALTO_30`=30
  - `SEG_POR_MIN`=60
  - BCD digit width 4
- Sub-module `bin_para_bcd_2dig`: combinational, 7-bit binary 0..99 to tens/units BCD. Instantiated twice, once for minutes and once for seconds.
- The top level holds the prescaler, the jump/saturation arithmetic and the output registers.

## Test plan
1. Reset, then 6000 consecutive `count` strobes → digits read 00:02, `pre`=0. Further strobes with `count`=0 → no change.
2. At 00:45, `salto_valor`=+30 → 01:15. At 01:05, -10 → 00:55. At 00:05, -10 → 00:00, saturated.
3. At 00:59 with `pre`=2999, `count`=1 and `salto_valido` with +30 in the same cycle → 01:30, `pre`=0.
4. At 99:50, +30 → 99:59 with `fim_contagem`=1. Another 3000 strobes → still 99:59. A -10 jump → 99:49 with `fim_contagem`=0.
5. Count to 00:10 with `pre`=1500, then pulse `prox_musica` → 00:00 and `pre`=0 on the next cycle. The next second tick occurs only after a full 3000 strobes.
6. `reset` and `salto_valido` (+30) asserted in the same cycle at 02:00 → 00:00, with the jump not applied.
